// File: rtl/header_wr_arbiter.sv
// header_wr_arbiter: round-robin scheduler for the write port of the block-header FIFO.
// One source owns the write port for a whole block of WORDS_PER_BLK 32-bit words.
// The grant is held until the block is complete, so blocks never interleave.
// Optional stall timeout with zero padding: define ARB_TIMEOUT_EN.
// Handshake: a word moves from granted source g when i_req_valid[g] and o_req_ready[g]
// are both high at a rising clk_wr edge. o_wr_en is high in exactly those cycles, and
// o_data_out carries the word in the same cycle. A stalled word stays at its source.
module header_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WORDS_PER_BLK = 16,
  parameter int TIMEOUT_CYC   = 256,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WW = $clog2(WORDS_PER_BLK) + 1
) (
  input  logic                    clk_wr,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*32-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic [NUM_REQ-1:0]      o_gnt,
  input  logic                    i_fifo_full,
  output logic                    o_wr_en,
  output logic [31:0]             o_data_out,
  output logic                    o_busy,
  output logic                    o_blk_done,
  output logic [IW-1:0]           o_blk_src,
  output logic                    o_timeout_err,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2,
    S_PAD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_gidx;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_blk_src;
  logic [WW-1:0]    r_wcnt;
  logic [31:0]      r_data_q;
  logic [IW-1:0]    w_pick;
  logic [IW-1:0]    w_pick_hi;
  logic [IW-1:0]    w_pick_lo;
  logic             w_hit_hi;
  logic             w_sel_valid;
  logic [31:0]      w_sel_data;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic             w_last;

  assign w_last      = (r_wcnt == WW'(WORDS_PER_BLK - 1));
  assign o_blk_src   = r_blk_src;
  assign o_dbg_state = r_state;

`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC) + 1;
  logic [SW-1:0] r_scnt;
  logic          r_timeout_err;
  logic          w_stall;
  logic          w_stall_hit;

  // A stall cycle is one where the FIFO could take a word but the owner has none.
  assign w_stall       = (r_state == S_XFER) && !w_sel_valid && !i_fifo_full;
  assign w_stall_hit   = w_stall && (r_scnt == SW'(TIMEOUT_CYC - 1));
  assign o_timeout_err = r_timeout_err;

  // Stall counter restarts on every write and outside XFER; the error flag is sticky.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      r_scnt        <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state != S_XFER || o_wr_en) begin
      r_scnt <= '0;
    end else if (w_stall_hit) begin
      r_timeout_err <= 1'b1;
    end else if (w_stall) begin
      r_scnt <= r_scnt + SW'(1);
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYC);
  assign o_timeout_err    = 1'b0;
`endif

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest requester overall.
  always_comb begin
    w_pick_hi = '0;
    w_pick_lo = '0;
    w_hit_hi  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_pick_lo = IW'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_pick_hi = IW'(i);
          w_hit_hi  = 1'b1;
        end
      end
    end
    w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;
  end

  // Mux the granted source's valid/data and decode its one-hot grant.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_gnt_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == IW'(i)) begin
        w_sel_valid = i_req_valid[i];
        w_sel_data  = i_req_data[32*i +: 32];
        w_gnt_oh[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: grant on any request, finish on the last word, fall to padding on timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (|i_req) w_next = S_XFER;
      S_XFER: begin
        if (o_wr_en && w_last) w_next = S_DONE;
`ifdef ARB_TIMEOUT_EN
        else if (w_stall_hit) w_next = S_PAD;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      S_PAD: if (o_wr_en && w_last) w_next = S_DONE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: pass the owner's word straight through; data_out holds when nothing is written.
  always_comb begin
    o_gnt       = '0;
    o_req_ready = '0;
    o_busy      = 1'b0;
    o_blk_done  = 1'b0;
    o_wr_en     = 1'b0;
    o_data_out  = r_data_q;
    case (r_state)
      S_XFER: begin
        o_busy      = 1'b1;
        o_gnt       = w_gnt_oh;
        o_req_ready = i_fifo_full ? '0 : w_gnt_oh;
        o_wr_en     = w_sel_valid && !i_fifo_full;
        if (o_wr_en) o_data_out = w_sel_data;
      end
`ifdef ARB_TIMEOUT_EN
      S_PAD: begin
        o_busy     = 1'b1;
        o_gnt      = w_gnt_oh;
        o_wr_en    = !i_fifo_full;
        o_data_out = 32'h0;
      end
`endif
      S_DONE: o_blk_done = 1'b1;
      default: ;
    endcase
  end

  // Grant bookkeeping, word counter, round-robin pointer and last-written data.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_blk_src <= '0;
      r_wcnt    <= '0;
      r_data_q  <= '0;
    end else begin
      if (o_wr_en) r_data_q <= o_data_out;
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_gidx    <= w_pick;
            r_blk_src <= w_pick;
            r_wcnt    <= '0;
          end
        end
        S_DONE: r_rr_ptr <= (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);
        default: if (o_wr_en) r_wcnt <= r_wcnt + WW'(1);
      endcase
    end
  end

endmodule
